// File: rtl/z80_bus_master_if.sv
// z80_bus_master_if
// Bundles the command/response handshake and the external Z80 bus pins of the
// bus cycle engine.
//   master modport : the engine (drives strobes, address, data, handshakes)
//   slave modport  : the command source plus the ebus pad side
// Signals:
//   cmd_*        command request (valid/ready, wr, io, inc, addr, len)
//   wr_data/next write data for the current beat and its consume pulse
//   abort        stop after the current bus cycle
//   rsp_*        read data response, done end-of-command pulse
//   bus_*        Z80 address, data, strobes and WAIT
interface z80_bus_master_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic              cmd_io;
  logic              cmd_inc;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_next;
  logic              abort;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              done;
  logic [ADDR_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_d_out;
  logic              bus_d_oe;
  logic [DATA_W-1:0] bus_d_in;
  logic              bus_rd_n;
  logic              bus_wr_n;
  logic              bus_mreq_n;
  logic              bus_iorq_n;
  logic              bus_wait_n;

  modport master (
    input  cmd_valid, cmd_wr, cmd_io, cmd_inc, cmd_addr, cmd_len, wr_data, abort,
    input  bus_d_in, bus_wait_n,
    output cmd_ready, wr_next, rsp_valid, rsp_data, done,
    output bus_a, bus_d_out, bus_d_oe, bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_io, cmd_inc, cmd_addr, cmd_len, wr_data, abort,
    output bus_d_in, bus_wait_n,
    input  cmd_ready, wr_next, rsp_valid, rsp_data, done,
    input  bus_a, bus_d_out, bus_d_oe, bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n
  );
endinterface

// File: rtl/z80_bus_master.sv
// z80_bus_master
// Z80-style bus cycle engine: turns single or burst memory/I/O read/write
// commands into T1/T2/TW/T3 bus cycles with WAIT handling and sticky abort.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus_if   z80_bus_master_if.master (command, response and ebus signals)
module z80_bus_master #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned T_DIV        = 2,
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned IO_AUTO_WAIT = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  z80_bus_master_if.master         bus_if
);
  localparam int unsigned CNT_W = $clog2(2 * T_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(2 * T_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SECOND = CNT_W'(T_DIV);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(T_DIV - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_TW   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_fw;       // forced Tw states still owed, incl. current one
  logic              r_wr;
  logic              r_io;
  logic              r_inc;
  logic              r_abort;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_beats;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp_data;
  logic [DATA_W-1:0] r_d_out;
  logic              r_d_oe;
  logic              r_rd_n;
  logic              r_wr_n;
  logic              r_mreq_n;
  logic              r_iorq_n;

  logic [2:0]        w_state_d;
  logic [CNT_W-1:0]  w_cnt_d;
  logic [1:0]        w_fw_d;
  logic              w_cnt_last;
  logic              w_accept;
  logic              w_end_t3;
  logic              w_next_beat;
  logic              w_capture;
  logic              w_strobe_d;
  logic              w_oe_d;

  // reset_n gates accept so no handshake pulse can appear while held in reset
  assign w_accept    = bus_if.cmd_valid && (r_state == S_IDLE) && reset_n;
  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign w_end_t3    = (r_state == S_T3) && w_cnt_last;
  assign w_next_beat = w_end_t3 && (r_beats != '0) && !(r_abort || bus_if.abort);
  assign w_capture   = (r_state == S_T3) && (r_cnt == CNT_MID) && !r_wr;

  always_comb begin
    w_state_d = r_state;
    w_fw_d    = r_fw;
    w_cnt_d   = (r_state == S_IDLE || w_cnt_last) ? '0 : r_cnt + 1'b1;
    if (r_state == S_IDLE) begin
      if (w_accept) w_state_d = S_T1;
    end else if (w_cnt_last) begin
      case (r_state)
        S_T1: w_state_d = S_T2;
        S_T2: begin
          if (r_io && (IO_AUTO_WAIT > 0)) begin
            w_state_d = S_TW;
            w_fw_d    = 2'(IO_AUTO_WAIT);
          end else if (!bus_if.bus_wait_n) begin
            w_state_d = S_TW;
            w_fw_d    = 2'd0;
          end else begin
            w_state_d = S_T3;
          end
        end
        S_TW: begin
          // WAIT is only honoured once the forced states have elapsed
          if (r_fw > 2'd1) begin
            w_fw_d = r_fw - 2'd1;
          end else begin
            w_fw_d = 2'd0;
            if (bus_if.bus_wait_n) w_state_d = S_T3;
          end
        end
        S_T3:    w_state_d = w_next_beat ? S_T1 : S_IDLE;
        default: w_state_d = S_IDLE;
      endcase
    end
  end

  // Bus pins are registered from the next state so strobes are glitch-free
  assign w_strobe_d = (w_state_d == S_T2) || (w_state_d == S_TW) ||
                      ((w_state_d == S_T3) && (w_cnt_d < CNT_SECOND));
  assign w_oe_d     = r_wr && (((w_state_d == S_T1) && (w_cnt_d >= CNT_SECOND)) ||
                      (w_state_d == S_T2) || (w_state_d == S_TW) || (w_state_d == S_T3));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_fw       <= 2'd0;
      r_wr       <= 1'b0;
      r_io       <= 1'b0;
      r_inc      <= 1'b0;
      r_abort    <= 1'b0;
      r_addr     <= '0;
      r_beats    <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_d_out    <= '0;
      r_d_oe     <= 1'b0;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_mreq_n   <= 1'b1;
      r_iorq_n   <= 1'b1;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_fw     <= w_fw_d;
      r_d_oe   <= w_oe_d;
      r_rd_n   <= !(w_strobe_d && !r_wr);
      r_wr_n   <= !(w_strobe_d && r_wr);
      r_mreq_n <= !(w_strobe_d && !r_io);
      r_iorq_n <= !(w_strobe_d && r_io);
      if (w_oe_d) r_d_out <= r_wdata;
      if (w_capture) r_rsp_data <= bus_if.bus_d_in;

      if (w_accept) begin
        r_wr    <= bus_if.cmd_wr;
        r_io    <= bus_if.cmd_io;
        r_inc   <= bus_if.cmd_inc;
        r_addr  <= bus_if.cmd_addr;
        r_beats <= bus_if.cmd_len;
        r_wdata <= bus_if.wr_data;
      end else if (w_next_beat) begin
        r_beats <= r_beats - 1'b1;
        if (r_inc) r_addr <= r_addr + 1'b1;
        if (r_wr) r_wdata <= bus_if.wr_data;
      end

      if (w_end_t3 && !w_next_beat) begin
        r_abort <= 1'b0;
      end else if ((r_state != S_IDLE) && bus_if.abort) begin
        r_abort <= 1'b1;
      end
    end
  end

  assign bus_if.cmd_ready  = (r_state == S_IDLE);
  assign bus_if.wr_next    = (w_accept && bus_if.cmd_wr) || (w_next_beat && r_wr);
  assign bus_if.done       = w_end_t3 && !w_next_beat;
  assign bus_if.rsp_valid  = w_capture;
  assign bus_if.rsp_data   = w_capture ? bus_if.bus_d_in : r_rsp_data;
  assign bus_if.bus_a      = r_addr;
  assign bus_if.bus_d_out  = r_d_out;
  assign bus_if.bus_d_oe   = r_d_oe;
  assign bus_if.bus_rd_n   = r_rd_n;
  assign bus_if.bus_wr_n   = r_wr_n;
  assign bus_if.bus_mreq_n = r_mreq_n;
  assign bus_if.bus_iorq_n = r_iorq_n;
endmodule
